// File: rtl/fpadd_param.sv
// Multi-cycle parametrised floating-point adder/subtractor with start/done handshake.
// Optional FPADD_PARAM_RNE_EN selects round-to-nearest-even; otherwise results truncate.
module fpadd_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   sub,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic [EXP_W+MAN_W:0]   sum,
  output logic                   done,
  output logic                   busy,
  output logic [2:0]             dbg_state
);
  localparam int W  = EXP_W + MAN_W + 1;
  localparam int MW = MAN_W + 5;
  localparam int XW = EXP_W + 1;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  // Handshake: start is sampled only in IDLE (busy=0); done is a one-cycle pulse
  // in DONE, and busy covers every cycle from the capture edge until done drops.
  typedef enum logic [2:0] {IDLE, SPECIAL, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_q, b_q, a_nxt, b_nxt, sum_q, sum_nxt;
  logic [MW-1:0] mx_q, my_q, m_q, mx_nxt, my_nxt, m_nxt;
  logic [XW-1:0] e_q, e_nxt;
  logic          s_q, s_nxt, esub_q, esub_nxt;

  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_f, b_f;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign {a_s, a_e, a_f} = a_q;
  assign {b_s, b_e, b_f} = b_q;
  assign a_nan  = (a_e == EXP_ONES) && (a_f != '0);
  assign b_nan  = (b_e == EXP_ONES) && (b_f != '0);
  assign a_inf  = (a_e == EXP_ONES) && (a_f == '0);
  assign b_inf  = (b_e == EXP_ONES) && (b_f == '0);
  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);

  // Larger magnitude becomes the reference, so the subtract in ADD never goes negative.
  logic             a_big, x_s;
  logic [EXP_W-1:0] x_e, y_e, sh_amt;
  logic [MAN_W-1:0] x_f, y_f;
  logic [MW-1:0]    y_full, y_shr, y_lost, m_sum;

  assign a_big  = a_q[W-2:0] >= b_q[W-2:0];
  assign x_s    = a_big ? a_s : b_s;
  assign x_e    = a_big ? a_e : b_e;
  assign x_f    = a_big ? a_f : b_f;
  assign y_e    = a_big ? b_e : a_e;
  assign y_f    = a_big ? b_f : a_f;
  assign sh_amt = x_e - y_e;
  assign y_full = {2'b01, y_f, 3'b000};
  assign y_shr  = y_full >> sh_amt;
  assign y_lost = y_full & ~({MW{1'b1}} << sh_amt);
  assign m_sum  = esub_q ? (mx_q - my_q) : (mx_q + my_q);

  logic [MAN_W-1:0] r_frac;
  logic [XW-1:0]    r_exp;
`ifdef FPADD_PARAM_RNE_EN
  logic          rnd_up;
  logic [MW-1:0] m_rnd;
  assign rnd_up = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
  assign m_rnd  = m_q + {{(MW-4){1'b0}}, rnd_up, 3'b000};
  assign r_frac = m_rnd[MW-1] ? m_rnd[MW-2:4] : m_rnd[MW-3:3];
  assign r_exp  = e_q + {{(XW-1){1'b0}}, m_rnd[MW-1]};
`else
  assign r_frac = m_q[MW-3:3];
  assign r_exp  = e_q;
`endif

  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    b_nxt     = b_q;
    mx_nxt    = mx_q;
    my_nxt    = my_q;
    m_nxt     = m_q;
    e_nxt     = e_q;
    s_nxt     = s_q;
    esub_nxt  = esub_q;
    sum_nxt   = sum_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          a_nxt     = a;
          b_nxt     = {b[W-1] ^ sub, b[W-2:0]};
          state_nxt = SPECIAL;
        end
      end
      SPECIAL: begin
        state_nxt = DONE;
        if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s))) sum_nxt = QNAN;
        else if (a_inf)              sum_nxt = a_q;
        else if (b_inf)              sum_nxt = b_q;
        else if (a_zero && b_zero)   sum_nxt = {a_s & b_s, {(W-1){1'b0}}};
        else if (a_zero)             sum_nxt = b_q;
        else if (b_zero)             sum_nxt = a_q;
        else                         state_nxt = ALIGN;
      end
      ALIGN: begin
        mx_nxt    = {2'b01, x_f, 3'b000};
        my_nxt    = {y_shr[MW-1:1], y_shr[0] | (|y_lost)};
        e_nxt     = {1'b0, x_e};
        s_nxt     = x_s;
        esub_nxt  = a_s ^ b_s;
        state_nxt = ADD;
      end
      ADD: begin
        if (m_sum == '0) begin
          sum_nxt   = '0;
          state_nxt = DONE;
        end else if (m_sum[MW-1]) begin
          m_nxt     = {1'b0, m_sum[MW-1:2], m_sum[1] | m_sum[0]};
          e_nxt     = e_q + 1'b1;
          state_nxt = NORM;
        end else begin
          m_nxt     = m_sum;
          state_nxt = NORM;
        end
      end
      NORM: begin
        if (!m_q[MW-2] && (e_q > XW'(1))) begin
          m_nxt = m_q << 1;
          e_nxt = e_q - 1'b1;
        end else begin
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        state_nxt = DONE;
        if (!m_q[MW-2])                     sum_nxt = {s_q, {(W-1){1'b0}}};
        else if (r_exp >= {1'b0, EXP_ONES}) sum_nxt = {s_q, EXP_ONES, {MAN_W{1'b0}}};
        else                                sum_nxt = {s_q, r_exp[EXP_W-1:0], r_frac};
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      mx_q   <= '0;
      my_q   <= '0;
      m_q    <= '0;
      e_q    <= '0;
      s_q    <= 1'b0;
      esub_q <= 1'b0;
      sum_q  <= '0;
    end else begin
      state  <= state_nxt;
      a_q    <= a_nxt;
      b_q    <= b_nxt;
      mx_q   <= mx_nxt;
      my_q   <= my_nxt;
      m_q    <= m_nxt;
      e_q    <= e_nxt;
      s_q    <= s_nxt;
      esub_q <= esub_nxt;
      sum_q  <= sum_nxt;
    end
  end

  assign sum       = sum_q;
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;
endmodule

// File: doc/fpadd_param.md
# fpadd_param

Parametrised multi-cycle IEEE-754-style floating-point adder/subtractor with configurable exponent and fraction widths and a start/done handshake. It handles zero, infinity, NaN, guard/round/sticky alignment, iterative normalisation and round-to-nearest-even. It replaces the fixed single-precision adder in the arithmetic datapath and presents the same start/done style to the controller.

## Interface
- EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1
- MAN_W, 23, stored fraction width; hidden bit is implicit
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while busy=0
- sub  in  1  0: a+b, 1: a-b (b sign inverted at capture)
- a  in  EXP_W+MAN_W+1  operand {sign, exp, frac}
- b  in  EXP_W+MAN_W+1  operand {sign, exp, frac}
- sum  out  EXP_W+MAN_W+1  result; holds until the next completion
- done  out  1  one-cycle completion pulse
- busy  out  1  high from the capture edge until done deasserts

## Operation
- States: IDLE, SPECIAL, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE: start=1 captures a, b and sub, then goes to SPECIAL. start while busy=1 is ignored.
- SPECIAL: exp=0 operands (zero or denormal) are flushed to signed zero.
- SPECIAL result priority:
  - any NaN → canonical qNaN {0, all-ones exp, 1 followed by zeros}
  - inf ± inf with opposite signs → qNaN
  - one inf → that inf
  - both zero → +0, or -0 only if both operands are -0
  - one zero → the other operand
- A SPECIAL result goes directly to DONE. Otherwise the next state is ALIGN.
- Internal mantissa: {carry, hidden, MAN_W frac, G, R, S} = MAN_W+5 bits.
- ALIGN:
  - the larger-exponent operand is the reference
  - the other operand is right-shifted by the exponent difference in a single cycle
  - bits shifted out are ORed into S
  - shift amounts ≥ MAN_W+3 leave only S
- ADD:
  - equal effective signs: add magnitudes
  - otherwise: subtract the smaller magnitude from the larger; result sign = sign of the larger
  - on carry: right-shift 1 (the LSB ORs into S) and exp+1
  - exact cancellation → +0, goes to DONE
- NORM: while hidden=0 and exp>1, left-shift 1 and exp-1, one shift per cycle. Leave for ROUND when hidden=1 or exp reaches 1.
- ROUND:
  - round-to-nearest-even on G, R, S
  - a mantissa carry from rounding right-shifts 1 and exp+1
  - exp ≥ all-ones → signed infinity
  - hidden=0 after NORM (underflow) → signed zero
- DONE: sum is registered, done=1 for one cycle, then IDLE.

## Timing
- Reset values: sum=0, done=0, busy=0, state=IDLE, all internal registers 0.
- Edge 0 is the capture edge; busy=1 from edge 0.
- Special or cancellation path: done is high in the cycle after edge 1 (special) or edge 3 (cancellation).
- Normal path: done is high in the cycle after edge 5+L, where L = number of NORM shifts (0..MAN_W+2).
- Worst-case latency for defaults: 30 cycles.
- busy falls on the same edge that deasserts done, so start may be accepted in the cycle after done.
- reset asserted mid-operation: immediate return to IDLE with the reset values; the partial result is discarded and done is not pulsed.
- start held high continuously: one operation per busy period; a new capture occurs on the first edge with busy=0.

## Configuration
- FPADD_PARAM_RNE_EN defined: ROUND performs round-to-nearest-even as described.
- FPADD_PARAM_RNE_EN undefined: ROUND truncates (G, R, S discarded), the rounding carry logic is removed, and latency is unchanged.

## Test plan
All values use the defaults (EXP_W=8, MAN_W=23) unless stated otherwise.
- 0x3F800000 + 0x3F800000 → sum=0x40000000; done after edge 5; done is exactly one cycle wide.
- sub=1, a=0x40400000, b=0x3F800000 → 0x40000000; a=0x3F800000, b=0x3F800000 with sub=1 → 0x00000000 via the cancellation path.
- 0x7F800000 + 0xFF800000 → 0x7FC00000 after edge 1. 0x7FC00001 + 1.0 → 0x7FC00000. 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
- Rounding with the macro defined:
  - 0x3F800000 + 0x33800000 (tie) → 0x3F800000
  - 0x3F800000 + 0x33800001 → 0x3F800001
- Same two additions with the macro undefined → both results are 0x3F800000.
- Cancellation to a small result: 0x3F800001 - 0x3F800000 (sub=1) → 0x34000000 with L=23, and done on the correct cycle.
- start pulses while busy are ignored.
- reset low at edge 3 gives done=0 and sum=0; a fresh start afterwards completes correctly.
- EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 → 0x4000.
